fact_accel_core: RTL

- Memory-mapped iterative factorial accelerator; one instance per factorial slot in the system address map.
- Consumes the per-slot write enable (fact0..fact3_we) from the address decoder, plus processor address/write-data.
- Drives read data back through the decoder-selected read mux and raises a done interrupt line to the interrupt controller.
- Computes n! by repeated 32-bit x 4-bit multiply, one step per cycle.

---
 rtl/fact_accel_core.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fact_accel_core.sv
// Memory-mapped iterative factorial accelerator: one 32x4 multiply step per
// cycle, with CTRL/STATUS/N/RESULT registers and a level done interrupt.
module fact_accel_core #(
    parameter int MAX_N = 12,
    parameter int N_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        done_int
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_N      = 2'd2;
    localparam logic [1:0] ADDR_RESULT = 2'd3;

    localparam logic [N_W-1:0] MAX_N_L = N_W'(MAX_N);
    localparam logic [N_W-1:0] ONE_N   = N_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [N_W-1:0]  n_reg;
    logic [N_W-1:0]  cnt;
    logic [31:0]     result;
    logic            done;
    logic            err;
    logic            busy;

    logic            ctrl_wr;
    logic            n_wr;
    logic            start;
    logic            reject;
    logic            clear;
    logic            step;
    logic            finish;

    // Only the low operand/control bits of the write bus are meaningful.
    logic            wd_hi_unused;

    // Product of the running result and a 4-bit factor, kept to 32 bits;
    // operands up to MAX_N never overflow.
    function automatic logic [31:0] mul_step(input logic [31:0] acc,
                                             input logic [N_W-1:0] factor);
        return acc * {{(32-N_W){1'b0}}, factor};
    endfunction

    assign wd_hi_unused = ^wd[31:N_W];

    assign busy     = (state == BUSY);
    assign done_int = done;
    assign ctrl_wr  = we && (addr == ADDR_CTRL);
    assign n_wr     = we && (addr == ADDR_N) && (state != BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // go takes priority over clr; control writes are ignored while busy.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        reject    = 1'b0;
        clear     = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (ctrl_wr && wd[0]) begin
                    if (n_reg > MAX_N_L) begin
                        reject    = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        start     = 1'b1;
                        state_nxt = BUSY;
                    end
                end else if (ctrl_wr && wd[1]) begin
                    clear     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (cnt <= ONE_N) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    step      = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_reg  <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (n_wr) begin
                n_reg <= wd[N_W-1:0];
            end
            if (start) begin
                result <= 32'd1;
                cnt    <= n_reg;
                done   <= 1'b0;
                err    <= 1'b0;
            end
            if (reject) begin
                result <= '0;
                err    <= 1'b1;
                done   <= 1'b1;
            end
            if (clear) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
            if (step) begin
                result <= mul_step(result, cnt);
                cnt    <= cnt - ONE_N;
            end
            if (finish) begin
                done <= 1'b1;
            end
        end
    end

    always_comb begin
        rd = '0;
        case (addr)
            ADDR_CTRL:   rd = '0;
            ADDR_STATUS: rd = {29'd0, busy, err, done};
            ADDR_N:      rd = {{(32-N_W){1'b0}}, n_reg};
            ADDR_RESULT: rd = result;
            default:     rd = '0;
        endcase
    end

endmodule
